// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction-fetch stage with a prefetch queue.
//
// Owns the fetch PC and issues sequential reads to a synchronous instruction ROM with a
// 1-cycle read latency. Returned words and their addresses are buffered in a DEPTH-entry
// FIFO that decode drains under stall_i. A redirect flushes the FIFO and discards the
// in-flight ROM response.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   jump_en_i       redirect request; jump_addr_i is the target
//   stall_i         decode cannot accept; holds the FIFO head
//   rom_inst_i      ROM data, valid the cycle after a read is issued
//   if2rom_ce_o     ROM read enable (one read per high cycle)
//   if2rom_addr_o   ROM read address (fetch PC)
//   inst_valid_o    FIFO head valid
//   inst_o          FIFO head instruction (0 when empty)
//   inst_addr_o     FIFO head address (0 when empty)
module ifetch_buf #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_i,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic              if2rom_ce_o,
  output logic [ADDR_W-1:0] if2rom_addr_o,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  // One extra bit so count + req_q cannot overflow before the compare.
  localparam int unsigned OccW = CntW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [OccW-1:0] occ_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              drop_q, drop_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  cnt_t              count_q, count_d;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic pop;
  logic push;
  logic issue;
  occ_t occ;

  always_comb begin
    inst_valid_o = (count_q != '0);
    pop          = inst_valid_o & ~stall_i & ~jump_en_i;
    // A response is only kept if it was not issued before a redirect.
    push         = req_q & ~drop_q & ~jump_en_i;
    // Occupancy after this cycle's pop, counting the read still in flight. Using the pop
    // here lets fetch resume in the same cycle a held stall is released.
    occ          = occ_t'(count_q) + occ_t'(req_q) - occ_t'(pop);
    issue        = ~rst & ~jump_en_i & (occ < occ_t'(DEPTH));
  end

  assign if2rom_ce_o   = issue;
  assign if2rom_addr_o = pc_q;
  assign inst_o        = inst_valid_o ? inst_mem_q[rd_ptr_q] : '0;
  assign inst_addr_o   = inst_valid_o ? addr_mem_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d       = pc_q;
    req_d      = issue;
    req_addr_d = req_addr_q;
    drop_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (jump_en_i) begin
      pc_d     = jump_addr_i;
      drop_d   = req_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        req_addr_d = pc_q;
        pc_d       = pc_q + ADDR_W'(PC_STEP);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= req_addr_q;
      inst_mem_q[wr_ptr_q] <= rom_inst_i;
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Testbench for ifetch_buf: directed vectors, a queue-based reference model checked every
// cycle, and hand-computed literal checks at the key points of each scenario.
module tb_ifetch_buf;

  localparam int          D    = 4;
  localparam int          STEP = 4;
  localparam logic [31:0] RPC  = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        stall = 1'b0;
  logic [31:0] rom_inst = '0;
  logic        ce;
  logic [31:0] rom_addr;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int reads    = 0;
  bit model_ok = 1'b0;

  ifetch_buf #(
    .ADDR_W  (32),
    .INST_W  (32),
    .DEPTH   (D),
    .PC_STEP (STEP),
    .RESET_PC(RPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .stall_i      (stall),
    .rom_inst_i   (rom_inst),
    .if2rom_ce_o  (ce),
    .if2rom_addr_o(rom_addr),
    .inst_valid_o (valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (ce) rom_inst <= rom_fn(rom_addr);
  end

  // Reference model: fetch PC, a queue of buffered addresses, one pending read.
  logic [31:0] m_pc = '0;
  logic [31:0] m_q[$];
  bit          m_pend = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_pend_addr = '0;

  function automatic bit m_pop();
    return (m_q.size() != 0) && !stall && !jump_en;
  endfunction

  function automatic bit m_ce();
    int occ;
    occ = m_q.size() + int'(m_pend) - int'(m_pop());
    return !rst && !jump_en && (occ < D);
  endfunction

  initial begin
    forever begin
      bit p;
      bit c;
      @(posedge clk);
      p = m_pop();
      c = m_ce();
      if (c) reads++;
      if (rst) begin
        m_pc = RPC;
        m_q.delete();
        m_pend = 1'b0;
        m_drop = 1'b0;
        model_ok = 1'b1;
      end else if (jump_en) begin
        m_q.delete();
        m_pc = jump_addr;
        m_drop = m_pend;
        m_pend = 1'b0;
      end else begin
        if (p) void'(m_q.pop_front());
        if (m_pend && !m_drop) m_q.push_back(m_pend_addr);
        m_drop = 1'b0;
        m_pend = c;
        if (c) begin
          m_pend_addr = m_pc;
          m_pc = m_pc + STEP;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("model_ce", 32'(ce), 32'(m_ce()));
        chk("model_rom_addr", rom_addr, m_pc);
        chk("model_valid", 32'(valid), 32'(m_q.size() != 0));
        chk("model_inst_addr", inst_addr, (m_q.size() != 0) ? m_q[0] : 32'h0);
        chk("model_inst", inst, (m_q.size() != 0) ? rom_fn(m_q[0]) : 32'h0);
        chk("count_le_depth", 32'(dut.count_q > D), 32'h0);
      end
    end
  end

  // One cycle: drive inputs just after the edge, return at the following negedge.
  task automatic cyc(input bit r, input bit j, input logic [31:0] ja, input bit s);
    @(posedge clk);
    #1;
    rst = r;
    jump_en = j;
    jump_addr = ja;
    stall = s;
    @(negedge clk);
  endtask

  initial begin
    int r0;
    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_addr", rom_addr, 32'h100);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    r0 = reads;

    // Startup, then stall held from cycle 2 through cycle 11
    cyc(0, 0, 0, 0);                       // cycle 0
    chk("c0_ce", 32'(ce), 32'h1);
    chk("c0_addr", rom_addr, 32'h100);
    chk("c0_valid", 32'(valid), 32'h0);
    cyc(0, 0, 0, 0);                       // cycle 1
    chk("c1_addr", rom_addr, 32'h104);
    chk("c1_valid", 32'(valid), 32'h0);
    cyc(0, 0, 0, 1);                       // cycle 2
    chk("c2_valid", 32'(valid), 32'h1);
    chk("c2_inst_addr", inst_addr, 32'h100);
    chk("c2_inst", inst, 32'h100 ^ 32'hDEAD_BEEF);
    chk("c2_addr", rom_addr, 32'h108);
    for (int i = 3; i <= 11; i++) cyc(0, 0, 0, 1);
    chk("bp_reads", 32'(reads - r0), 32'd4);
    chk("bp_count", 32'(dut.count_q), 32'd4);
    chk("bp_head", inst_addr, 32'h100);
    chk("bp_ce", 32'(ce), 32'h0);

    // Release: drain back-to-back, fetch resumes at 0x110
    cyc(0, 0, 0, 0);                       // cycle 12
    chk("rel_ce", 32'(ce), 32'h1);
    chk("rel_addr", rom_addr, 32'h110);
    chk("rel_head0", inst_addr, 32'h100);
    cyc(0, 0, 0, 0);
    chk("rel_head1", inst_addr, 32'h104);
    cyc(0, 0, 0, 0);
    chk("rel_head2", inst_addr, 32'h108);
    cyc(0, 0, 0, 0);
    chk("rel_head3", inst_addr, 32'h10C);
    cyc(0, 0, 0, 0);
    chk("rel_head4", inst_addr, 32'h110);
    chk("rel_valid4", 32'(valid), 32'h1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

    // Redirect with a read in flight
    cyc(0, 1, 32'h2000, 0);                // N
    chk("jmp_ce", 32'(ce), 32'h0);
    chk("jmp_req", 32'(dut.req_q), 32'h1);
    cyc(0, 0, 0, 0);                       // N+1
    chk("jmp1_ce", 32'(ce), 32'h1);
    chk("jmp1_addr", rom_addr, 32'h2000);
    chk("jmp1_valid", 32'(valid), 32'h0);
    cyc(0, 0, 0, 0);                       // N+2
    chk("jmp2_valid", 32'(valid), 32'h0);
    chk("jmp2_addr", rom_addr, 32'h2004);
    cyc(0, 0, 0, 0);                       // N+3
    chk("jmp3_valid", 32'(valid), 32'h1);
    chk("jmp3_head", inst_addr, 32'h2000);
    cyc(0, 0, 0, 0);
    chk("jmp4_head", inst_addr, 32'h2004);

    // Fill under stall, then jump while stalled and full
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("full_count", 32'(dut.count_q), 32'd4);
    cyc(0, 1, 32'h3000, 1);                // N
    cyc(0, 0, 0, 1);                       // N+1
    chk("js1_valid", 32'(valid), 32'h0);
    chk("js1_count", 32'(dut.count_q), 32'h0);
    chk("js1_ce", 32'(ce), 32'h1);
    chk("js1_addr", rom_addr, 32'h3000);
    cyc(0, 0, 0, 1);                       // N+2
    chk("js2_valid", 32'(valid), 32'h0);
    cyc(0, 0, 0, 1);                       // N+3
    chk("js3_valid", 32'(valid), 32'h1);
    chk("js3_head", inst_addr, 32'h3000);
    cyc(0, 0, 0, 1);                       // N+4
    chk("js4_head", inst_addr, 32'h3000);

    // Reset for one cycle with count=3 and a read in flight
    cyc(1, 0, 0, 1);                       // N+5
    chk("mr_count", 32'(dut.count_q), 32'd3);
    chk("mr_req", 32'(dut.req_q), 32'h1);
    chk("mr_ce", 32'(ce), 32'h0);
    cyc(0, 0, 0, 0);
    chk("mr1_valid", 32'(valid), 32'h0);
    chk("mr1_ce", 32'(ce), 32'h1);
    chk("mr1_addr", rom_addr, 32'h100);
    cyc(0, 0, 0, 0);
    chk("mr2_valid", 32'(valid), 32'h0);
    cyc(0, 0, 0, 0);
    chk("mr3_valid", 32'(valid), 32'h1);
    chk("mr3_head", inst_addr, 32'h100);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    // Address wrap-around
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0);
    chk("wr1_addr", rom_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wr2_addr", rom_addr, 32'h0000_0000);
    cyc(0, 0, 0, 0);
    chk("wr3_head", inst_addr, 32'hFFFF_FFFC);
    chk("wr3_inst", inst, 32'hFFFF_FFFC ^ 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0);
    chk("wr4_head", inst_addr, 32'h0000_0000);
    chk("wr4_inst", inst, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0);
    chk("wr5_head", inst_addr, 32'h0000_0004);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
